// File: rtl/udp_line_sched.sv
// Round-robin scheduler sharing the UDP transmit path between two camera line sources.
// Issues one trig per line and supervises the send for timeout and length errors, then enforces a gap.
module udp_line_sched #(
    parameter int H_ACT      = 1280,
    parameter int ROW_W      = 11,
    parameter int GAP_CYCLES = 64,
    parameter int TIMEOUT    = 4096
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             cam1_req,
    input  logic [ROW_W-1:0] cam1_row,
    input  logic             cam2_req,
    input  logic [ROW_W-1:0] cam2_row,
    input  logic             tx_busy,
    input  logic             tx_read_en,
    input  logic             err_clr,
    output logic             cam1_gnt,
    output logic             cam2_gnt,
    output logic             tx_trig,
    output logic [15:0]      tx_index,
    output logic             err_timeout,
    output logic             err_len,
    output logic [15:0]      sent_cnt,
    output logic [2:0]       fsm_state
);
    // Handshake: a camN_req is sampled only in IDLE and must stay high until its one-cycle camN_gnt;
    // tx_trig is a one-cycle start, after which tx_busy high marks the send and each tx_read_en cycle is one byte.

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_TRIG       = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_GAP        = 3'd4
    } state_t;

    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = 11;
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [15:0]   BYTES_EXP = 16'(H_ACT);

    state_t        state, state_nx;
    logic [CW-1:0] cyc_cnt;
    logic [15:0]   byte_cnt;
    logic          last_cam2;
    logic          pick_cam2;
    logic          timeout_hit;
    logic          set_timeout;
    logic          set_len;
    logic          pkt_done;
    logic          count_byte;

    always_comb begin
        state_nx    = state;
        set_timeout = 1'b0;
        pkt_done    = 1'b0;
        count_byte  = 1'b0;
        // On a tie the camera not served last wins; otherwise whoever is asking.
        pick_cam2   = (cam1_req && cam2_req) ? ~last_cam2 : cam2_req;
        timeout_hit = (cyc_cnt == TO_LAST);
        case (state)
            S_IDLE: if (enable && (cam1_req || cam2_req)) state_nx = S_TRIG;
            S_TRIG: state_nx = S_WAIT_START;
            S_WAIT_START: begin
                if (tx_busy) begin
                    state_nx   = S_WAIT_DONE;
                    count_byte = tx_read_en;
                end else if (timeout_hit) begin
                    state_nx    = S_GAP;
                    set_timeout = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx = S_GAP;
                    pkt_done = 1'b1;
                end else if (timeout_hit) begin
                    state_nx    = S_GAP;
                    set_timeout = 1'b1;
                end else begin
                    count_byte = tx_read_en;
                end
            end
            S_GAP: if (cyc_cnt == GAP_LAST) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        set_len   = pkt_done && (byte_cnt != BYTES_EXP);
        tx_trig   = (state == S_TRIG);
        cam1_gnt  = tx_trig && !last_cam2;
        cam2_gnt  = tx_trig && last_cam2;
        fsm_state = state;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            cyc_cnt     <= '0;
            byte_cnt    <= '0;
            last_cam2   <= 1'b1;
            tx_index    <= '0;
            err_timeout <= 1'b0;
            err_len     <= 1'b0;
            sent_cnt    <= '0;
        end else begin
            state <= state_nx;
            // One counter serves both the wait timeouts and the gap; it restarts on every state change.
            cyc_cnt <= (state_nx == state) ? cyc_cnt + 1'b1 : '0;
            if (state == S_IDLE && state_nx == S_TRIG) begin
                last_cam2 <= pick_cam2;
                tx_index  <= pick_cam2 ? {5'd2, RW'(cam2_row)} : {5'd1, RW'(cam1_row)};
            end
            if (state == S_TRIG) byte_cnt <= '0;
            else if (count_byte && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 1'b1;
            if (err_clr) err_timeout <= 1'b0;
            else if (set_timeout) err_timeout <= 1'b1;
            if (err_clr) err_len <= 1'b0;
            else if (set_len) err_len <= 1'b1;
            if (pkt_done) sent_cnt <= sent_cnt + 1'b1;
        end
    end
endmodule
